// File: rtl/prog_seq_pkg.sv
// Shared types for program_sequencer: FSM state encoding, error codes and halt opcode.
// Halt is detected from two opcode bits of the current instruction word.
package prog_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALT   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_WDOG     = 2'd2
  } err_code_e;

  localparam logic [1:0] HALT_OPC = 2'b11;
  localparam int         HALT_MSB = 30;
  localparam int         HALT_LSB = 29;

  function automatic logic is_halt(input logic [31:0] word);
    return word[HALT_MSB:HALT_LSB] == HALT_OPC;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// RUN-state stall counter: clears on clr, counts while en, flags expiry at LIMIT-1.
// Present only when PROG_SEQ_WATCHDOG_EN is defined; expiry is a combinational decode of the count.
`ifdef PROG_SEQ_WATCHDOG_EN
module seq_watchdog #(
  parameter int LIMIT = 65535,
  parameter int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = en && (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/program_sequencer.sv
// Loads a host program into the instruction buffer, commits it, then steps the PC on exec_ready until halt.
// Write strobe 1 cycle after handshake, commit pulse 2 cycles after last word; optional stall watchdog via PROG_SEQ_WATCHDOG_EN.
module program_sequencer
  import prog_seq_pkg::*;
#(
  parameter int NUM_INSTR   = 4096,
  parameter int ADDR_W      = 12,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              instr_wr_en,
  output logic [ADDR_W-1:0] instr_wr_addr,
  output logic [31:0]       instr_wr_data,
  output logic              instr_vld,
  input  logic [31:0]       instr,
  input  logic              exec_ready,
  output logic              inc_pc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   instr_count
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LOAD   = ST_LOAD;
  localparam logic [2:0] S_COMMIT = ST_COMMIT;
  localparam logic [2:0] S_RUN    = ST_RUN;
  localparam logic [2:0] S_HALT   = ST_HALT;
  localparam logic [2:0] S_ERR    = ST_ERR;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INSTR - 1);
  localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(NUM_INSTR);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              vld_q, vld_d;

  logic halt;
  logic wdog_exp;
  logic unused_instr_bits;

  assign halt              = is_halt(instr);
  assign unused_instr_bits = ^{instr[31], instr[28:0]};

  assign inc_pc        = (state_q == S_RUN) && exec_ready && !halt;
  assign load_ready    = (state_q == S_LOAD);
  assign busy          = (state_q == S_LOAD) || (state_q == S_COMMIT) || (state_q == S_RUN);
  assign done          = (state_q == S_HALT);
  assign err           = (state_q == S_ERR);
  assign err_code      = err_code_q;
  assign instr_count   = cnt_q;
  assign instr_wr_en   = wr_en_q;
  assign instr_wr_addr = wr_addr_q;
  assign instr_wr_data = wr_data_q;
  assign instr_vld     = vld_q;

`ifdef PROG_SEQ_WATCHDOG_EN
  logic wdog_clr;

  // Restart the stall window on entry to RUN and on every issued instruction.
  assign wdog_clr = ((state_d == S_RUN) && (state_q != S_RUN)) || inc_pc;

  seq_watchdog #(
    .LIMIT (WDOG_CYCLES)
  ) u_seq_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wdog_clr),
    .en      (state_q == S_RUN),
    .expired (wdog_exp)
  );
`else
  assign wdog_exp = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    vld_d      = 1'b0;

    if (inc_pc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (abort) begin
      state_d    = S_IDLE;
      err_code_d = ERR_NONE;
    end else begin
      case (state_q)
        S_IDLE, S_HALT, S_ERR: begin
          if (start) begin
            state_d    = S_LOAD;
            wcnt_d     = '0;
            cnt_d      = '0;
            err_code_d = ERR_NONE;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wcnt_q;
            wr_data_d = load_data;
            wcnt_d    = wcnt_q + 1'b1;
            if (load_last) begin
              state_d = S_COMMIT;
            end else if (wcnt_q == LAST_ADDR) begin
              // Buffer is full and the host still has more words: the final one is kept.
              state_d    = S_ERR;
              err_code_d = ERR_OVERFLOW;
            end
          end
        end
        S_COMMIT: begin
          vld_d   = 1'b1;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (halt && exec_ready) begin
            state_d = S_HALT;
          end else if (wdog_exp && !inc_pc) begin
            state_d    = S_ERR;
            err_code_d = ERR_WDOG;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      cnt_q      <= '0;
      err_code_q <= ERR_NONE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      vld_q      <= vld_d;
    end
  end

endmodule
